integer_issue_queue: RTL

//  Receiving end of the dispatch-to-issue-queue interface for the integer pipe.

---
 rtl/integer_issue_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/integer_issue_queue.sv
// integer_issue_queue: collapsing issue queue for the integer pipe; CDB snoop, oldest-ready select, branch flush.
// Optional ISSUEQ_CDB_BYPASS_EN: a source dispatched in the same cycle as its CDB broadcast is captured on the spot.
module integer_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6,
    parameter int OP_WIDTH   = 4,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          dispatch_en_integer,
    input  logic [OP_WIDTH-1:0]           dispatch_opcode,
    input  logic [TAG_WIDTH-1:0]          dispatch_rd_tag,
    input  logic [DATA_WIDTH-1:0]         dispatch_rs1_data,
    input  logic [TAG_WIDTH-1:0]          dispatch_rs1_tag,
    input  logic                          dispatch_rs1_valid,
    input  logic [DATA_WIDTH-1:0]         dispatch_rs2_data,
    input  logic [TAG_WIDTH-1:0]          dispatch_rs2_tag,
    input  logic                          dispatch_rs2_valid,
    input  logic                          CDB_valid,
    input  logic [TAG_WIDTH-1:0]          CDB_tag,
    input  logic [DATA_WIDTH-1:0]         CDB_data,
    input  logic                          CDB_branch,
    input  logic                          CDB_branch_taken,
    input  logic                          issue_ready,
    output logic                          issueque_full_integer,
    output logic                          issue_valid,
    output logic [OP_WIDTH-1:0]           issue_opcode,
    output logic [TAG_WIDTH-1:0]          issue_rd_tag,
    output logic [DATA_WIDTH-1:0]         issue_rs1_data,
    output logic [DATA_WIDTH-1:0]         issue_rs2_data,
    output logic [$clog2(DEPTH+1)-1:0]    issueque_count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);
    typedef struct packed {
        logic [OP_WIDTH-1:0]   op;
        logic [TAG_WIDTH-1:0]  rd;
        logic [DATA_WIDTH-1:0] d1;
        logic [TAG_WIDTH-1:0]  t1;
        logic                  r1;
        logic [DATA_WIDTH-1:0] d2;
        logic [TAG_WIDTH-1:0]  t2;
        logic                  r2;
    } entry_t;
    entry_t q [DEPTH];
    entry_t sn [DEPTH];
    entry_t nxt [DEPTH];
    entry_t din;
    logic [CW-1:0] count, wpos;
    logic [DEPTH-1:0] ready;
    logic [IW-1:0] sel;
    logic flush, fire, wr, byp1, byp2;
    assign flush = CDB_branch && CDB_branch_taken;
    assign issueque_full_integer = count == CW'(DEPTH);
    assign issueque_count = count;
    assign issue_valid = |ready && !flush;
    assign fire = issue_valid && issue_ready;
    assign wr = dispatch_en_integer && !issueque_full_integer && !flush;
    assign wpos = count - CW'(fire);
    assign issue_opcode = issue_valid ? q[sel].op : '0;
    assign issue_rd_tag = issue_valid ? q[sel].rd : '0;
    assign issue_rs1_data = issue_valid ? q[sel].d1 : '0;
    assign issue_rs2_data = issue_valid ? q[sel].d2 : '0;
`ifdef ISSUEQ_CDB_BYPASS_EN
    assign byp1 = !dispatch_rs1_valid && CDB_valid && dispatch_rs1_tag == CDB_tag;
    assign byp2 = !dispatch_rs2_valid && CDB_valid && dispatch_rs2_tag == CDB_tag;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif
    assign din = '{op: dispatch_opcode, rd: dispatch_rd_tag,
                   d1: byp1 ? CDB_data : dispatch_rs1_data, t1: dispatch_rs1_tag, r1: dispatch_rs1_valid | byp1,
                   d2: byp2 ? CDB_data : dispatch_rs2_data, t2: dispatch_rs2_tag, r2: dispatch_rs2_valid | byp2};
    // Readiness uses only registered source bits, so a CDB hit wakes an entry one edge later.
    always_comb begin
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sn[i] = q[i];
            if (CDB_valid && !q[i].r1 && q[i].t1 == CDB_tag) begin
                sn[i].r1 = 1'b1;
                sn[i].d1 = CDB_data;
            end
            if (CDB_valid && !q[i].r2 && q[i].t2 == CDB_tag) begin
                sn[i].r2 = 1'b1;
                sn[i].d2 = CDB_data;
            end
            ready[i] = CW'(i) < count && q[i].r1 && q[i].r2;
        end
    end
    always_comb begin
        sel = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            sel = ready[i] ? IW'(i) : sel;
    end
    // Collapse over the issued slot, then append the dispatched op behind the survivors.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            int src;
            src = (fire && j >= int'(sel) && j < DEPTH-1) ? j+1 : j;
            nxt[j] = sn[src];
            if (wr && CW'(j) == wpos)
                nxt[j] = din;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++)
                q[i] <= '0;
        end else begin
            count <= flush ? '0 : count + CW'(wr) - CW'(fire);
            for (int i = 0; i < DEPTH; i++)
                q[i] <= nxt[i];
        end
    end
endmodule
